// File: rtl/nibble_accumulator_if.sv
// Operand-in / result-out handshake bundle for nibble_accumulator.
// slave is the accumulator's view; master is the producer/consumer side.
interface nibble_accumulator_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_sum;
    logic       out_carry;
    logic       out_overflow;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_carry, out_overflow
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_carry, out_overflow
    );
endinterface

// File: rtl/nibble_accumulator.sv
// Sums groups of COUNT 4-bit operands through a single ripple adder, tracking
// sticky carry-out and signed overflow, and hands each group total downstream.

module FullAdder4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] sum,
    output logic       carryout,
    output logic       overflow
);
    logic [4:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign carryout = c[4];
    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign overflow = c[4] ^ c[3];
endmodule

// state | meaning
// IDLE  | no operand of the current group taken yet
// ACCUM | 1..COUNT-1 operands taken, accumulating
// DONE  | group result held on the output port until out_ready
module nibble_accumulator #(
    parameter int COUNT = 4,
    parameter int CW    = 3
) (
    input  logic                clk,
    input  logic                reset,
    nibble_accumulator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

    localparam logic [CW-1:0] LAST_CNT = CW'(COUNT - 1);

    state_e        state_q, state_d;
    logic [3:0]    acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic          ovf_q, ovf_d;

    logic          in_ready_w;
    logic          out_valid_w;
    logic          accept;
    logic [3:0]    add_sum;
    logic          add_co;
    logic          add_ov;

    FullAdder4bit u_adder (
        .a        (acc_q),
        .b        (bus.in_data),
        .sum      (add_sum),
        .carryout (add_co),
        .overflow (add_ov)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = (cnt_q == LAST_CNT) ? DONE : ACCUM;
            ACCUM:   if (accept && (cnt_q == LAST_CNT)) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready_w  = (state_q != DONE);
        out_valid_w = (state_q == DONE);
    end

    assign accept           = bus.in_valid & in_ready_w;
    assign bus.in_ready     = in_ready_w;
    assign bus.out_valid    = out_valid_w;
    assign bus.out_sum      = acc_q;
    assign bus.out_carry    = carry_q;
    assign bus.out_overflow = ovf_q;

    // Leaving DONE clears the group; accept can never coincide since in_ready is low.
    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        if (out_valid_w && bus.out_ready) begin
            acc_d   = 4'd0;
            cnt_d   = '0;
            carry_d = 1'b0;
            ovf_d   = 1'b0;
        end else if (accept) begin
            acc_d   = add_sum;
            cnt_d   = cnt_q + CW'(1);
            carry_d = carry_q | add_co;
            ovf_d   = ovf_q | add_ov;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q   <= 4'd0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_nibble_accumulator.sv
// Scoreboard bench: a COUNT=4 and a COUNT=1 accumulator driven with directed
// and random operand groups; expected results are checked on output handshakes.
module tb_nibble_accumulator;
    typedef struct packed {
        logic [3:0] sum;
        logic       c;
        logic       v;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    nibble_accumulator_if if_a();
    nibble_accumulator_if if_b();

    nibble_accumulator #(.COUNT(4), .CW(3)) dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
    nibble_accumulator #(.COUNT(1), .CW(1)) dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    bit   rnd_a = 1'b0;
    bit   rnd_b = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] ops[4], input int n);
        exp_t       e;
        logic [4:0] s;
        e = '0;
        for (int i = 0; i < n; i++) begin
            s   = {1'b0, e.sum} + {1'b0, ops[i]};
            e.c = e.c | s[4];
            e.v = e.v | ((e.sum[3] == ops[i][3]) && (s[3] != e.sum[3]));
            e.sum = s[3:0];
        end
        return e;
    endfunction

    // Random out_ready is drawn before sampling so the pair seen here is the
    // pair the next rising edge acts on.
    always @(negedge clk) begin
        if (rnd_a) if_a.out_ready = 1'($urandom_range(0, 1));
        if (rnd_b) if_b.out_ready = 1'($urandom_range(0, 1));
        if (!reset && if_a.out_valid && if_a.out_ready) begin
            if (q_a.size() == 0) chk("a_unexpected_out", 1, 0);
            else begin
                ea = q_a.pop_front();
                chk("a_sum", if_a.out_sum, ea.sum);
                chk("a_carry", if_a.out_carry, ea.c);
                chk("a_ovf", if_a.out_overflow, ea.v);
            end
        end
        if (!reset && if_b.out_valid && if_b.out_ready) begin
            if (q_b.size() == 0) chk("b_unexpected_out", 1, 0);
            else begin
                eb = q_b.pop_front();
                chk("b_sum", if_b.out_sum, eb.sum);
                chk("b_carry", if_b.out_carry, eb.c);
                chk("b_ovf", if_b.out_overflow, eb.v);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit sel, input logic v, input logic [3:0] d);
        if (sel) begin
            if_b.in_valid = v;
            if_b.in_data  = d;
        end else begin
            if_a.in_valid = v;
            if_a.in_data  = d;
        end
    endtask

    // Entered and left just after a rising edge; returns right after the accepting edge.
    task automatic send(input bit sel, input logic [3:0] d, input int gap);
        int guard;
        if (gap > 0) begin
            drv(sel, 1'b0, d);
            repeat (gap) step();
        end
        drv(sel, 1'b1, d);
        guard = 0;
        while (!(sel ? if_b.in_ready : if_a.in_ready) && guard < 100) begin
            step();
            guard++;
        end
        if (guard >= 100) chk("in_ready_timeout", 0, 1);
        step();
    endtask

    task automatic run_group(input bit sel, input logic [3:0] ops[4], input int n, input int maxgap);
        exp_t e;
        e = model(ops, n);
        if (sel) q_b.push_back(e);
        else     q_a.push_back(e);
        for (int i = 0; i < n; i++)
            send(sel, ops[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        drv(sel, 1'b0, 4'd0);
    endtask

    task automatic drain(input bit sel);
        int g;
        g = 0;
        while (((sel ? q_b.size() : q_a.size()) != 0) && g < 200) begin
            step();
            g++;
        end
        chk(sel ? "b_drain" : "a_drain", sel ? q_b.size() : q_a.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ops[4];
        exp_t       e;

        reset = 1'b1;
        if_a.in_valid = 1'b0; if_a.in_data = 4'd0; if_a.out_ready = 1'b1;
        if_b.in_valid = 1'b0; if_b.in_data = 4'd0; if_b.out_ready = 1'b1;
        repeat (3) step();
        chk("rst_in_ready", if_a.in_ready, 1);
        chk("rst_out_valid", if_a.out_valid, 0);
        chk("rst_sum", if_a.out_sum, 0);
        chk("rst_carry", if_a.out_carry, 0);
        chk("rst_ovf", if_a.out_overflow, 0);
        reset = 1'b0;
        step();

        // 1,2,3,4 back-to-back: 10, no carry, 6+4 overflows signed
        ops = '{4'd1, 4'd2, 4'd3, 4'd4};
        q_a.push_back('{sum: 4'd10, c: 1'b0, v: 1'b1});
        send(0, ops[0], 0);
        send(0, ops[1], 0);
        send(0, ops[2], 0);
        chk("lat_not_yet", if_a.out_valid, 0);
        send(0, ops[3], 0);
        chk("lat_valid", if_a.out_valid, 1);
        chk("lat_in_ready", if_a.in_ready, 0);
        drv(0, 1'b0, 4'd0);
        step();
        chk("back_idle", if_a.out_valid, 0);

        q_a.push_back('{sum: 4'd12, c: 1'b1, v: 1'b0});
        send(0, 4'd14, 0);
        send(0, 4'd14, 0);
        send(0, 4'd0, 0);
        send(0, 4'd0, 0);
        drv(0, 1'b0, 4'd0);
        step();

        // Back-pressure hold with in_valid asserted throughout DONE
        if_a.out_ready = 1'b0;
        ops = '{4'd5, 4'd9, 4'd3, 4'd8};
        e = model(ops, 4);
        q_a.push_back(e);
        for (int i = 0; i < 4; i++) send(0, ops[i], 0);
        drv(0, 1'b1, 4'hF);
        for (int k = 0; k < 5; k++) begin
            chk("hold_in_ready", if_a.in_ready, 0);
            chk("hold_valid", if_a.out_valid, 1);
            chk("hold_sum", if_a.out_sum, 4'd9);
            chk("hold_carry", if_a.out_carry, 1);
            chk("hold_ovf", if_a.out_overflow, 0);
            step();
        end
        if_a.out_ready = 1'b1;
        drv(0, 1'b0, 4'd0);
        step();
        chk("release_in_ready", if_a.in_ready, 1);
        chk("release_valid", if_a.out_valid, 0);
        run_group(0, '{4'd1, 4'd1, 4'd1, 4'd1}, 4, 0);
        drain(0);

        // Reset mid-group discards the partial 7+7
        send(0, 4'd7, 0);
        send(0, 4'd7, 0);
        drv(0, 1'b0, 4'd0);
        chk("pre_rst_sum", if_a.out_sum, 4'd14);
        reset = 1'b1;
        #1;
        chk("mid_rst_sum", if_a.out_sum, 0);
        chk("mid_rst_ovf", if_a.out_overflow, 0);
        chk("mid_rst_in_ready", if_a.in_ready, 1);
        step();
        reset = 1'b0;
        step();
        run_group(0, '{4'd1, 4'd1, 4'd1, 4'd1}, 4, 0);
        drain(0);

        // Gappy in_valid must give the same result as back-to-back
        for (int r = 0; r < 4; r++) run_group(0, '{4'd1, 4'd2, 4'd3, 4'd4}, 4, 3);
        drain(0);

        rnd_a = 1'b1;
        for (int g = 0; g < 300; g++) begin
            for (int i = 0; i < 4; i++) ops[i] = 4'($urandom_range(0, 15));
            run_group(0, ops, 4, 2);
        end
        drain(0);
        rnd_a = 1'b0;
        step();
        if_a.out_ready = 1'b1;

        rnd_b = 1'b1;
        for (int g = 0; g < 1000; g++) begin
            ops = '{4'($urandom_range(0, 15)), 4'd0, 4'd0, 4'd0};
            run_group(1, ops, 1, 2);
        end
        drain(1);
        rnd_b = 1'b0;
        step();
        if_b.out_ready = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
